// File: rtl/dma_block_ctr.sv
// Single-channel block-transfer DMA controller.
// Copies dcount words from a source to a destination address over the shared
// bus, one read cycle then one write cycle per word, arbitrating with the CPU
// through the active-low breq_/bgrt_ handshake. Each side may increment or
// stay fixed (for I/O ports), and cycle-steal mode hands the bus back to the
// CPU for one cycle between words. eop_ pulses low once at the end.
module dma_block_ctr #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] odata,
  input  logic [DW-1:0] idata,
  output logic          rw_,
  output logic          breq_,
  input  logic          bgrt_,
  input  logic [AW-1:0] dsaddr,
  input  logic [AW-1:0] ddaddr,
  input  logic [LW-1:0] dlen,
  input  logic [2:0]    dmode,
  input  logic          dreq_,
  output logic          eop_,
  output logic          busy,
  output logic [LW-1:0] dcount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    REL   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] odata_reg, odata_next;
  logic          rw_reg, rw_next;
  logic          breq_reg, breq_next;
  logic          eop_reg, eop_next;
  logic          busy_reg, busy_next;
  logic [LW-1:0] dcount_reg, dcount_next;
  logic [AW-1:0] src_reg, src_next;
  logic [AW-1:0] dst_reg, dst_next;
  logic [2:0]    mode_reg, mode_next;

  // State and every output register; reset drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      odata_reg  <= '0;
      rw_reg     <= 1'b1;
      breq_reg   <= 1'b1;
      eop_reg    <= 1'b1;
      busy_reg   <= 1'b0;
      dcount_reg <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      mode_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      odata_reg  <= odata_next;
      rw_reg     <= rw_next;
      breq_reg   <= breq_next;
      eop_reg    <= eop_next;
      busy_reg   <= busy_next;
      dcount_reg <= dcount_next;
      src_reg    <= src_next;
      dst_reg    <= dst_next;
      mode_reg   <= mode_next;
    end
  end

  // Next-state and next-output logic; everything holds unless a state changes it.
  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    odata_next  = odata_reg;
    rw_next     = rw_reg;
    breq_next   = breq_reg;
    eop_next    = eop_reg;
    busy_next   = busy_reg;
    dcount_next = dcount_reg;
    src_next    = src_reg;
    dst_next    = dst_reg;
    mode_next   = mode_reg;

    case (state_reg)
      IDLE: begin
        if (!dreq_) begin
          src_next    = dsaddr;
          dst_next    = ddaddr;
          dcount_next = dlen;
          mode_next   = dmode;
          busy_next   = 1'b1;
          if (dlen == '0) begin
            // Empty transfer: never touch the bus, just signal completion.
            eop_next   = 1'b0;
            state_next = DONE;
          end else begin
            breq_next  = 1'b0;
            state_next = REQ;
          end
        end
      end

      REQ: begin
        breq_next = 1'b0;
        if (!bgrt_) begin
          addr_next  = src_reg;
          rw_next    = 1'b1;
          state_next = READ;
        end
      end

      READ: begin
        // idata is captured at the end of the read cycle and becomes the write data.
        addr_next   = dst_reg;
        rw_next     = 1'b0;
        odata_next  = idata;
        dcount_next = dcount_reg - LW'(1);
        if (mode_reg[0]) src_next = src_reg + AW'(1);
        if (mode_reg[1]) dst_next = dst_reg + AW'(1);
        state_next  = WRITE;
      end

      WRITE: begin
        rw_next = 1'b1;
        if (dcount_reg == '0) begin
          eop_next   = 1'b0;
          breq_next  = 1'b1;
          state_next = DONE;
        end else if (mode_reg[2]) begin
          breq_next  = 1'b1;
          state_next = REL;
        end else if (!bgrt_) begin
          addr_next  = src_reg;
          state_next = READ;
        end else begin
          // Grant pulled mid-burst: keep requesting and resume at current src/dst.
          breq_next  = 1'b0;
          state_next = REQ;
        end
      end

      REL: begin
        // Bus released for exactly this one cycle before re-requesting.
        breq_next  = 1'b0;
        state_next = REQ;
      end

      DONE: begin
        // dreq_ is not looked at here, so a new start needs one more edge.
        eop_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign addr   = addr_reg;
  assign odata  = odata_reg;
  assign rw_    = rw_reg;
  assign breq_  = breq_reg;
  assign eop_   = eop_reg;
  assign busy   = busy_reg;
  assign dcount = dcount_reg;

endmodule

// File: tb/tb_dma_block_ctr.sv
// Directed bench for dma_block_ctr: reset, burst, fixed-destination I/O,
// cycle-steal, grant withdrawal with address wrap, empty transfer and
// reset during a write. Control outputs are checked as the packed group
// {rw_, breq_, eop_, busy, dcount}.
module tb_dma_block_ctr;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [DW-1:0] odata;
  logic [DW-1:0] idata;
  logic          rw_;
  logic          breq_;
  logic          bgrt_;
  logic [AW-1:0] dsaddr;
  logic [AW-1:0] ddaddr;
  logic [LW-1:0] dlen;
  logic [2:0]    dmode;
  logic          dreq_;
  logic          eop_;
  logic          busy;
  logic [LW-1:0] dcount;

  int checks = 0;
  int errors = 0;
  logic [11:0] ctl;

  always #5 clk = ~clk;

  // Memory model: every address returns a distinct, address-derived word.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  assign idata = mem_word(addr);
  assign ctl   = {rw_, breq_, eop_, busy, dcount};

  dma_block_ctr #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .addr(addr), .odata(odata), .idata(idata),
    .rw_(rw_), .breq_(breq_), .bgrt_(bgrt_), .dsaddr(dsaddr), .ddaddr(ddaddr),
    .dlen(dlen), .dmode(dmode), .dreq_(dreq_), .eop_(eop_), .busy(busy),
    .dcount(dcount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a transfer and hold dreq_ low across exactly one edge.
  task automatic start_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LW-1:0] n, input logic [2:0] m);
    dsaddr = s; ddaddr = d; dlen = n; dmode = m;
    dreq_ = 1'b0;
    tick();
    dreq_ = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; dreq_ = 1'b1; bgrt_ = 1'b1;
    dsaddr = '0; ddaddr = '0; dlen = '0; dmode = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (addr !== 16'h0000 || odata !== 32'h0 || ctl !== {1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: got addr=%h odata=%h ctl=%h, expected addr=0000 odata=0 ctl=%h",
               addr, odata, ctl, {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (addr !== 16'h0000 || ctl !== {1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL idle_hold cyc=%0d: got addr=%h ctl=%h, expected addr=0000 ctl=%h",
                 i, addr, ctl, {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
      end
    end
    $display("reset: idle held for 10 cycles");
  endtask

  task automatic test_burst();
    bgrt_ = 1'b0;
    start_xfer(16'h0100, 16'h0200, 8'd4, 3'b011);
    checks++;
    if (ctl !== {1'b1, 1'b0, 1'b1, 1'b1, 8'd4}) begin
      errors++;
      $display("FAIL burst_req: got ctl=%h, expected %h", ctl, {1'b1, 1'b0, 1'b1, 1'b1, 8'd4});
    end
    for (int w = 0; w < 4; w++) begin
      tick();
      checks++;
      if (addr !== 16'h0100 + 16'(w) || ctl !== {1'b1, 1'b0, 1'b1, 1'b1, 8'(4 - w)}) begin
        errors++;
        $display("FAIL burst_read w=%0d: got addr=%h ctl=%h, expected addr=%h ctl=%h",
                 w, addr, ctl, 16'h0100 + 16'(w), {1'b1, 1'b0, 1'b1, 1'b1, 8'(4 - w)});
      end
      tick();
      checks++;
      if (addr !== 16'h0200 + 16'(w) || odata !== mem_word(16'h0100 + 16'(w)) ||
          ctl !== {1'b0, 1'b0, 1'b1, 1'b1, 8'(3 - w)}) begin
        errors++;
        $display("FAIL burst_write w=%0d: got addr=%h odata=%h ctl=%h, expected addr=%h odata=%h ctl=%h",
                 w, addr, odata, ctl, 16'h0200 + 16'(w), mem_word(16'h0100 + 16'(w)),
                 {1'b0, 1'b0, 1'b1, 1'b1, 8'(3 - w)});
      end
      $display("burst: word %0d %h -> %h", w, 16'h0100 + 16'(w), 16'h0200 + 16'(w));
    end
    tick();
    checks++;
    if (ctl !== {1'b1, 1'b1, 1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL burst_eop: got ctl=%h, expected %h", ctl, {1'b1, 1'b1, 1'b0, 1'b1, 8'd0});
    end
    tick();
    checks++;
    if (ctl !== {1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL burst_idle: got ctl=%h, expected %h", ctl, {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
    end
  endtask

  task automatic test_io_port();
    bgrt_ = 1'b0;
    start_xfer(16'h0300, 16'h00F0, 8'd3, 3'b001);
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++;
      if (addr !== 16'h0300 + 16'(w) || rw_ !== 1'b1) begin
        errors++;
        $display("FAIL io_read w=%0d: got addr=%h rw_=%b, expected addr=%h rw_=1",
                 w, addr, rw_, 16'h0300 + 16'(w));
      end
      tick();
      checks++;
      if (addr !== 16'h00F0 || rw_ !== 1'b0 || odata !== mem_word(16'h0300 + 16'(w))) begin
        errors++;
        $display("FAIL io_write w=%0d: got addr=%h rw_=%b odata=%h, expected addr=00f0 rw_=0 odata=%h",
                 w, addr, rw_, odata, mem_word(16'h0300 + 16'(w)));
      end
      $display("io: word %0d %h -> 00f0", w, 16'h0300 + 16'(w));
    end
    tick();
    checks++;
    if (eop_ !== 1'b0 || breq_ !== 1'b1) begin
      errors++;
      $display("FAIL io_eop: got eop_=%b breq_=%b, expected eop_=0 breq_=1", eop_, breq_);
    end
    tick();
  endtask

  task automatic test_cycle_steal();
    bgrt_ = 1'b0;
    start_xfer(16'h0400, 16'h0500, 8'd2, 3'b111);
    tick();
    tick();
    checks++;
    if (addr !== 16'h0500 || ctl !== {1'b0, 1'b0, 1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL steal_write0: got addr=%h ctl=%h, expected addr=0500 ctl=%h",
               addr, ctl, {1'b0, 1'b0, 1'b1, 1'b1, 8'd1});
    end
    $display("steal: word 0 0400 -> 0500");
    tick();
    checks++;
    if (ctl !== {1'b1, 1'b1, 1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL steal_release: got ctl=%h, expected %h", ctl, {1'b1, 1'b1, 1'b1, 1'b1, 8'd1});
    end
    bgrt_ = 1'b1;
    tick();
    tick();
    checks++;
    if (addr !== 16'h0500 || ctl !== {1'b1, 1'b0, 1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL steal_rereq: got addr=%h ctl=%h, expected addr=0500 ctl=%h",
               addr, ctl, {1'b1, 1'b0, 1'b1, 1'b1, 8'd1});
    end
    bgrt_ = 1'b0;
    tick();
    checks++;
    if (addr !== 16'h0401 || rw_ !== 1'b1) begin
      errors++;
      $display("FAIL steal_read1: got addr=%h rw_=%b, expected addr=0401 rw_=1", addr, rw_);
    end
    tick();
    checks++;
    if (addr !== 16'h0501 || rw_ !== 1'b0 || odata !== mem_word(16'h0401)) begin
      errors++;
      $display("FAIL steal_write1: got addr=%h rw_=%b odata=%h, expected addr=0501 rw_=0 odata=%h",
               addr, rw_, odata, mem_word(16'h0401));
    end
    $display("steal: word 1 0401 -> 0501");
    tick();
    checks++;
    if (eop_ !== 1'b0) begin
      errors++;
      $display("FAIL steal_eop: got eop_=%b, expected 0", eop_);
    end
    tick();
  endtask

  task automatic test_grant_withdraw();
    bgrt_ = 1'b0;
    start_xfer(16'hFFFF, 16'h0010, 8'd3, 3'b011);
    tick();
    tick();
    checks++;
    if (addr !== 16'h0010 || odata !== mem_word(16'hFFFF) || ctl !== {1'b0, 1'b0, 1'b1, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL wd_write0: got addr=%h odata=%h ctl=%h, expected addr=0010 odata=%h ctl=%h",
               addr, odata, ctl, mem_word(16'hFFFF), {1'b0, 1'b0, 1'b1, 1'b1, 8'd2});
    end
    $display("withdraw: word 0 ffff -> 0010");
    bgrt_ = 1'b1;
    tick();
    tick();
    checks++;
    if (addr !== 16'h0010 || ctl !== {1'b1, 1'b0, 1'b1, 1'b1, 8'd2}) begin
      errors++;
      $display("FAIL wd_wait: got addr=%h ctl=%h, expected addr=0010 ctl=%h",
               addr, ctl, {1'b1, 1'b0, 1'b1, 1'b1, 8'd2});
    end
    bgrt_ = 1'b0;
    for (int w = 1; w < 3; w++) begin
      tick();
      checks++;
      if (addr !== 16'(w - 1) || rw_ !== 1'b1) begin
        errors++;
        $display("FAIL wd_read w=%0d: got addr=%h rw_=%b, expected addr=%h rw_=1",
                 w, addr, rw_, 16'(w - 1));
      end
      tick();
      checks++;
      if (addr !== 16'h0010 + 16'(w) || rw_ !== 1'b0 || odata !== mem_word(16'(w - 1))) begin
        errors++;
        $display("FAIL wd_write w=%0d: got addr=%h rw_=%b odata=%h, expected addr=%h rw_=0 odata=%h",
                 w, addr, rw_, odata, 16'h0010 + 16'(w), mem_word(16'(w - 1)));
      end
      $display("withdraw: word %0d %h -> %h", w, 16'(w - 1), 16'h0010 + 16'(w));
    end
    tick();
    checks++;
    if (ctl !== {1'b1, 1'b1, 1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL wd_eop: got ctl=%h, expected %h", ctl, {1'b1, 1'b1, 1'b0, 1'b1, 8'd0});
    end
    tick();
  endtask

  task automatic test_zero_len();
    bgrt_ = 1'b0;
    dsaddr = 16'h0800; ddaddr = 16'h0900; dlen = 8'd0; dmode = 3'b011;
    dreq_ = 1'b0;
    tick();
    checks++;
    if (ctl !== {1'b1, 1'b1, 1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL zero_eop: got ctl=%h, expected %h", ctl, {1'b1, 1'b1, 1'b0, 1'b1, 8'd0});
    end
    // dreq_ still low across the DONE edge: must not restart yet.
    tick();
    checks++;
    if (ctl !== {1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL zero_done_ignores_dreq: got ctl=%h, expected %h", ctl, {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
    end
    dreq_ = 1'b1;
    tick();
    $display("zero_len: empty transfer completed");
  endtask

  task automatic test_reset_mid_write();
    bgrt_ = 1'b0;
    start_xfer(16'h0600, 16'h0700, 8'd4, 3'b011);
    tick();
    tick();
    checks++;
    if (rw_ !== 1'b0 || addr !== 16'h0700) begin
      errors++;
      $display("FAIL rst_pre: got addr=%h rw_=%b, expected addr=0700 rw_=0", addr, rw_);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (addr !== 16'h0000 || odata !== 32'h0 || ctl !== {1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL rst_mid: got addr=%h odata=%h ctl=%h, expected addr=0000 odata=0 ctl=%h",
               addr, odata, ctl, {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ctl !== {1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL rst_after cyc=%0d: got ctl=%h, expected %h", i, ctl, {1'b1, 1'b1, 1'b1, 1'b0, 8'd0});
      end
    end
    $display("reset_mid_write: transfer dropped");
  endtask

  initial begin
    test_reset();
    test_burst();
    test_io_port();
    test_cycle_steal();
    test_grant_withdraw();
    test_zero_len();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
